pipe_share_scheduler: RTL and testbench
=======================================

# pipe_share_scheduler

Scheduler that shares one fixed-latency register delay pipeline (default three stages) between two requesters. Each cycle it grants at most one requester round-robin and tags the accepted beat with the requester ID. It pauses the whole pipeline when `en` is low and routes each beat to the owning requester's output exactly DEPTH cycles after acceptance. It sits between two producer blocks and the shared delay/retiming datapath.

## Interface
Parameters:
- DATA_W, 8, width of each data beat
- DEPTH, 3, number of pipeline stages (legal range 1..16)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  pipeline advance enable; 0 = stall everything
- req0_valid  in  1  requester 0 has a beat
- req0_data  in  DATA_W  requester 0 beat
- req0_ready  out  1  requester 0 beat accepted this cycle
- req1_valid  in  1  requester 1 has a beat
- req1_data  in  DATA_W  requester 1 beat
- req1_ready  out  1  requester 1 beat accepted this cycle
- out0_valid  out  1  delayed beat for requester 0, one-cycle pulse
- out0_data  out  DATA_W  delayed data for requester 0
- out1_valid  out  1  delayed beat for requester 1, one-cycle pulse
- out1_data  out  DATA_W  delayed data for requester 1
- in_flight  out  $clog2(DEPTH+1)  number of valid beats currently in stages 1..DEPTH

## Operation
- A handshake occurs when reqX_valid & reqX_ready.
- reqX_ready is combinational: en & grantX.
- Requesters must not make valid depend on ready. Once valid is raised, it holds with stable data until the handshake.
- Arbitration:
  - only req0 valid → grant0; only req1 valid → grant1; neither valid → no grant.
  - both valid → grant the requester not granted most recently.
  - last_grant updates only on a completed handshake.
- Each stage holds {valid, tag, data}. When en=1, stage 1 loads {handshake, granted ID, granted data}; an idle slot loads valid=0 with data and tag held. Stage k loads stage k-1.
- When en=0, all stages, last_grant and in_flight hold, and both readys are 0.
- Output demux reads the final stage and is registered with the pipeline:
  - out0_valid = final.valid & en_d & tag==0; out1_valid likewise for tag==1. Here en_d is en registered, so a stalled beat pulses only once.
  - outX_data shows the final-stage data whenever outX_valid=1. Otherwise it holds its last value.
- in_flight is incremented on a handshake and decremented when a valid beat leaves the final stage. Both in the same cycle → unchanged. Never exceeds DEPTH.
- Reset behaviour:
  - Reset values: all stage valids 0; out0_valid=out1_valid=0; out0_data=out1_data=0; in_flight=0; last_grant=1, so req0 wins the first tie.
  - Reset mid-operation discards all in-flight beats; no output pulse appears in the cycle after reset.
  - readys are 0 while rst=1.

## Timing
- A beat handshaken in cycle c appears on outX_valid/outX_data in cycle c+DEPTH (DEPTH=3 → 3 cycles), provided en=1 for cycles c..c+DEPTH-1.
- Each stalled cycle adds exactly one cycle of latency. Order is always preserved.
- Throughput is one beat per enabled cycle. With both requesters saturated, grants alternate 0,1,0,1…
- out0_valid and out1_valid are never both 1.
- DEPTH=1: beat appears in c+1.

## Structure
- Shared package `pipe_sched_pkg`: tag constants REQ0=1'b0 and REQ1=1'b1, and DEFAULT_DEPTH=3.
- Sub-module `tagged_delay_pipe` (params DATA_W, DEPTH): the stall-able {valid, tag, data} shift chain with a sync reset on the valids.
- The top level holds the arbiter, last_grant, in_flight counter and output demux.

## Test plan
- Reset, then req0 only with data 0xA5 in cycle 2 → req0_ready=1 in cycle 2; out0_valid=1 with 0xA5 in cycle 5; out1_valid stays 0; in_flight goes 1 then back to 0.
- Both requesters valid for 4 cycles from cycle 2 (req0 0x10..0x13, req1 0x20..0x23) → grants alternate starting with req0; outputs in cycles 5–8 are 0x10, 0x20, 0x11, 0x21.
- Handshake of 0x3C at cycle 2, en=0 in cycles 3–4 → out0_valid in cycle 7 only, single pulse; readys are 0 during the stall.
- Pipeline full with three beats, rst=1 for one cycle → no outX_valid afterwards, in_flight=0, and the next tie goes to req0.
- Handshake every cycle while one beat exits every cycle → in_flight steady at 3, never 4.
- DEPTH=1 build: req1 0x7E in cycle 2 → out1_valid with 0x7E in cycle 3.

Source files
------------

// File: rtl/pipe_sched_pkg.sv
// Shared tag constants and default depth for the shared delay-pipe scheduler.
package pipe_sched_pkg;

    localparam logic REQ0          = 1'b0;
    localparam logic REQ1          = 1'b1;
    localparam int   DEFAULT_DEPTH = 3;

endpackage

// File: rtl/tagged_delay_pipe.sv
// Stall-able {valid, tag, data} shift chain; DEPTH enabled cycles from load to last stage.
// en=0 freezes every stage; only the valids carry a reset.
module tagged_delay_pipe #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_valid,
    input  logic              load_tag,
    input  logic [DATA_W-1:0] load_data,
    output logic              last_valid,
    output logic              last_tag,
    output logic [DATA_W-1:0] last_data
);

    logic [DEPTH-1:0]  stage_valid;
    logic [DEPTH-1:0]  stage_tag;
    logic [DATA_W-1:0] stage_data [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
        end else if (en) begin
            stage_valid[0] <= load_valid;
            for (int k = 1; k < DEPTH; k++) begin
                stage_valid[k] <= stage_valid[k-1];
            end
        end
    end

    // Idle slots keep the old tag/data in stage 1 so the datapath does not toggle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (load_valid) begin
                stage_tag[0]  <= load_tag;
                stage_data[0] <= load_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage_tag[k]  <= stage_tag[k-1];
                stage_data[k] <= stage_data[k-1];
            end
        end
    end

    assign last_valid = stage_valid[DEPTH-1];
    assign last_tag   = stage_tag[DEPTH-1];
    assign last_data  = stage_data[DEPTH-1];

endmodule

// File: rtl/pipe_share_scheduler.sv
// Round-robin sharing of one DEPTH-stage delay pipe between two requesters, beats demuxed by tag.
// Latency DEPTH enabled cycles; en=0 stalls everything and drops both readys.
module pipe_share_scheduler
    import pipe_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       req0_valid,
    input  logic [DATA_W-1:0]          req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [DATA_W-1:0]          req1_data,
    output logic                       req1_ready,
    output logic                       out0_valid,
    output logic [DATA_W-1:0]          out0_data,
    output logic                       out1_valid,
    output logic [DATA_W-1:0]          out1_data,
    output logic [$clog2(DEPTH+1)-1:0] in_flight
);

    localparam int CW = $clog2(DEPTH+1);

    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              hs0;
    logic              hs1;
    logic              hs;
    logic              leave;
    logic              en_d;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;
    logic              final_valid;
    logic              final_tag;
    logic [DATA_W-1:0] final_data;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | (last_grant == REQ1));
        grant1 = req1_valid & (~req0_valid | (last_grant == REQ0));
    end

    assign req0_ready = en & grant0 & ~rst;
    assign req1_ready = en & grant1 & ~rst;
    assign hs0        = req0_valid & req0_ready;
    assign hs1        = req1_valid & req1_ready;
    assign hs         = hs0 | hs1;

    tagged_delay_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (hs),
        .load_tag   (hs1 ? REQ1 : REQ0),
        .load_data  (hs1 ? req1_data : req0_data),
        .last_valid (final_valid),
        .last_tag   (final_tag),
        .last_data  (final_data)
    );

    assign leave = en & final_valid;

    // en_d keeps a beat parked in the final stage during a stall from pulsing twice.
    assign out0_valid = final_valid & en_d & (final_tag == REQ0);
    assign out1_valid = final_valid & en_d & (final_tag == REQ1);
    assign out0_data  = out0_valid ? final_data : hold0;
    assign out1_data  = out1_valid ? final_data : hold1;
    assign in_flight  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ1;
            en_d       <= 1'b0;
            count      <= '0;
            hold0      <= '0;
            hold1      <= '0;
        end else begin
            en_d <= en;
            if (hs0) begin
                last_grant <= REQ0;
            end else if (hs1) begin
                last_grant <= REQ1;
            end
            case ({hs, leave})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (out0_valid) begin
                hold0 <= final_data;
            end
            if (out1_valid) begin
                hold1 <= final_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_share_scheduler.sv
// Directed and random checks of pipe_share_scheduler against a queue-based beat model.
module tb_pipe_share_scheduler;

    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       out0_valid;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic [7:0] out1_data;
    logic [1:0] in_flight;

    logic       s_req0_valid;
    logic [7:0] s_req0_data;
    logic       s_req0_ready;
    logic       s_req1_valid;
    logic [7:0] s_req1_data;
    logic       s_req1_ready;
    logic       s_out0_valid;
    logic [7:0] s_out0_data;
    logic       s_out1_valid;
    logic [7:0] s_out1_data;
    logic       s_in_flight;

    pipe_share_scheduler #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out0_valid(out0_valid), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_data(out1_data),
        .in_flight(in_flight)
    );

    pipe_share_scheduler #(.DATA_W(8), .DEPTH(1)) dut_d1 (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(s_req0_valid), .req0_data(s_req0_data), .req0_ready(s_req0_ready),
        .req1_valid(s_req1_valid), .req1_data(s_req1_data), .req1_ready(s_req1_ready),
        .out0_valid(s_out0_valid), .out0_data(s_out0_data),
        .out1_valid(s_out1_valid), .out1_data(s_out1_data),
        .in_flight(s_in_flight)
    );

    int checks = 0;
    int errors = 0;

    // Beats in flight, oldest first; age = enabled cycles elapsed since acceptance.
    bit         q_tag  [$];
    logic [7:0] q_data [$];
    int         q_age  [$];
    bit         m_last;
    logic [7:0] m_hold0;
    logic [7:0] m_hold1;
    bit         m_en_prev;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_tag.delete();
        q_data.delete();
        q_age.delete();
        m_last    = 1'b1;
        m_hold0   = 8'h00;
        m_hold1   = 8'h00;
        m_en_prev = 1'b0;
    endtask

    // Entered and left at posedge+1.
    task automatic step(input logic e, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1,
                        output logic h0, output logic h1);
        logic g0, g1, pulse, e0, e1;
        en = e; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
        #2;
        pulse = m_en_prev && (q_age.size() > 0) && (q_age[0] == DEPTH);
        e0 = pulse && (q_tag[0] == 1'b0);
        e1 = pulse && (q_tag[0] == 1'b1);
        if (e0) m_hold0 = q_data[0];
        if (e1) m_hold1 = q_data[0];
        chk(32'(out0_valid), 32'(e0), "out0_valid");
        chk(32'(out0_data), 32'(m_hold0), "out0_data");
        chk(32'(out1_valid), 32'(e1), "out1_valid");
        chk(32'(out1_data), 32'(m_hold1), "out1_data");
        chk(32'(in_flight), 32'(q_age.size()), "in_flight");
        g0 = v0 && (!v1 || m_last);
        g1 = v1 && (!v0 || !m_last);
        h0 = e && g0;
        h1 = e && g1;
        chk(32'(req0_ready), 32'(h0), "req0_ready");
        chk(32'(req1_ready), 32'(h1), "req1_ready");
        @(posedge clk);
        if (e) begin
            if (q_age.size() > 0 && q_age[0] == DEPTH) begin
                void'(q_tag.pop_front());
                void'(q_data.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i]++;
            if (h0 || h1) begin
                q_tag.push_back(h1);
                q_data.push_back(h1 ? d1 : d0);
                q_age.push_back(1);
            end
            if (h0) m_last = 1'b0;
            else if (h1) m_last = 1'b1;
        end
        m_en_prev = e;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; s_req1_valid = 1'b1;
        #2;
        chk(32'(req0_ready), 0, "rst_ready0");
        chk(32'(req1_ready), 0, "rst_ready1");
        chk(32'(s_req1_ready), 0, "rst_d1_ready1");
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; s_req1_valid = 1'b0;
    endtask

    initial begin
        logic       h0, h1;
        logic       rv0, rv1;
        logic [7:0] rd0, rd1;
        int         i0, i1;

        rst = 1'b1; en = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req1_valid = 1'b0; req1_data = 8'h00;
        s_req0_valid = 1'b0; s_req0_data = 8'h00; s_req1_valid = 1'b0; s_req1_data = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk(32'(out0_valid), 0, "reset_out0_valid");
        chk(32'(out1_valid), 0, "reset_out1_valid");
        chk(32'(out0_data), 0, "reset_out0_data");
        chk(32'(out1_data), 0, "reset_out1_data");
        chk(32'(in_flight), 0, "reset_in_flight");

        // Single req0 beat through the pipe.
        step(1, 1, 8'hA5, 0, 8'h00, h0, h1);
        chk(32'(h0), 1, "a5_accepted");
        chk(32'(in_flight), 1, "a5_in_flight_1");
        step(1, 0, 8'h00, 0, 8'h00, h0, h1);
        step(1, 0, 8'h00, 0, 8'h00, h0, h1);
        chk(32'(out0_valid), 1, "a5_out0_valid");
        chk(32'(out0_data), 32'h A5, "a5_out0_data");
        chk(32'(out1_valid), 0, "a5_out1_quiet");
        step(1, 0, 8'h00, 0, 8'h00, h0, h1);
        chk(32'(out0_valid), 0, "a5_single_pulse");
        chk(32'(in_flight), 0, "a5_in_flight_0");

        // Both requesters contend for four handshakes.
        do_reset();
        i0 = 0; i1 = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, (i0 + i1) < 4, 8'(8'h10 + i0), (i0 + i1) < 4, 8'(8'h20 + i1), h0, h1);
            if (h0) i0++;
            if (h1) i1++;
            if (i >= 2 && i < 6) begin
                if (((i - 2) % 2) == 0) begin
                    chk(32'(out0_valid), 1, "alt_out0_valid");
                    chk(32'(out0_data), 32'(8'h10 + (i - 2) / 2), "alt_out0_data");
                end else begin
                    chk(32'(out1_valid), 1, "alt_out1_valid");
                    chk(32'(out1_data), 32'(8'h20 + (i - 2) / 2), "alt_out1_data");
                end
            end
        end

        // Two-cycle stall behind an accepted beat; req1 waits through the stall.
        do_reset();
        step(1, 1, 8'h3C, 0, 8'h00, h0, h1);
        step(0, 0, 8'h00, 1, 8'h55, h0, h1);
        step(0, 0, 8'h00, 1, 8'h55, h0, h1);
        step(1, 0, 8'h00, 1, 8'h55, h0, h1);
        chk(32'(out0_valid), 0, "stall_no_early");
        step(1, 0, 8'h00, 0, 8'h00, h0, h1);
        chk(32'(out0_valid), 1, "stall_out0_valid");
        chk(32'(out0_data), 32'h3C, "stall_out0_data");
        step(1, 0, 8'h00, 0, 8'h00, h0, h1);
        chk(32'(out0_valid), 0, "stall_single_pulse");
        step(1, 0, 8'h00, 0, 8'h00, h0, h1);

        // Fill the pipe, then reset over it.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 8'(i + 1), 0, 8'h00, h0, h1);
        chk(32'(in_flight), 3, "full_in_flight");
        do_reset();
        chk(32'(in_flight), 0, "flush_in_flight");
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 0, 8'h00, h0, h1);
            chk(32'(out0_valid | out1_valid), 0, "flush_no_pulse");
        end
        step(1, 1, 8'h44, 1, 8'h66, h0, h1);
        chk(32'(h0), 1, "flush_tie_req0");

        // Saturated req0 stream: occupancy sits at DEPTH.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 8'(8'h80 + i), 0, 8'h00, h0, h1);
            if (i >= 2) chk(32'(in_flight), 3, "steady_in_flight");
        end

        // Random traffic with stalls and occasional resets.
        do_reset();
        rv0 = 1'b0; rv1 = 1'b0; rd0 = 8'h00; rd1 = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if (!rv0) begin rv0 = 1'($urandom_range(0, 1)); rd0 = 8'($urandom); end
            if (!rv1) begin rv1 = 1'($urandom_range(0, 1)); rd1 = 8'($urandom); end
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
                rv0 = 1'b0; rv1 = 1'b0;
            end else begin
                step(1'($urandom_range(0, 3) != 0), rv0, rd0, rv1, rd1, h0, h1);
                if (h0) rv0 = 1'b0;
                if (h1) rv1 = 1'b0;
                chk(32'(out0_valid & out1_valid), 0, "rand_exclusive");
            end
        end

        // DEPTH=1 build.
        do_reset();
        chk(32'(s_out1_data), 0, "d1_reset_data");
        chk(32'(s_in_flight), 0, "d1_reset_in_flight");
        s_req1_valid = 1'b1; s_req1_data = 8'h7E; en = 1'b1;
        #1;
        chk(32'(s_req1_ready), 1, "d1_ready1");
        step(1, 0, 8'h00, 0, 8'h00, h0, h1);
        s_req1_valid = 1'b0;
        chk(32'(s_out1_valid), 1, "d1_out1_valid");
        chk(32'(s_out1_data), 32'h7E, "d1_out1_data");
        chk(32'(s_out0_valid), 0, "d1_out0_quiet");
        chk(32'(s_in_flight), 1, "d1_in_flight_1");
        step(1, 0, 8'h00, 0, 8'h00, h0, h1);
        chk(32'(s_out1_valid), 0, "d1_single_pulse");
        chk(32'(s_out1_data), 32'h7E, "d1_data_held");
        chk(32'(s_in_flight), 0, "d1_in_flight_0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
